// File: rtl/am_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : am_ctrl_pkg
// Purpose  : Shared types and defaults for the AM transmitter output chain
//            (output sequencer and modulator amplitude path).
// Contents : state_t      - 3-bit sequencer state encoding
//            c_gain_w     - default gain width
//            c_ramp_step  - default gain slew per clock
//            c_arm_cycles - default watchdog arm time before RF is allowed
//            c_safe_state - state used when an illegal encoding is seen
// Revision : 1.0 - initial release
// ============================================================================
package am_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int          c_gain_w     = 16;
    localparam logic [15:0] c_ramp_step  = 16'h0100;
    localparam int          c_arm_cycles = 16;

    // Any corrupted state register resolves here: RF muted, fault latched.
    localparam state_t      c_safe_state = ST_FAULT;

endpackage : am_ctrl_pkg
`default_nettype wire

// File: rtl/gain_slew.sv
`default_nettype none
// ============================================================================
// Module   : gain_slew
// Purpose  : Combinational saturating slew: moves cur one step toward goal
//            without overshooting it and without unsigned wrap.
// Ports    : cur  - present gain
//            goal - gain being approached
//            step - maximum change allowed
//            next - cur +/- step, clamped to goal
// Revision : 1.0 - initial release
// ============================================================================
module gain_slew
    import am_ctrl_pkg::*;
#(
    parameter int W = c_gain_w
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] goal,
    input  logic [W-1:0] step,
    output logic [W-1:0] next
);

    // One extra bit catches carry-out on the way up and borrow on the way
    // down, so targets near full scale never wrap.
    logic [W:0] w_up;
    logic [W:0] w_dn;

    assign w_up = {1'b0, cur} + {1'b0, step};
    assign w_dn = {1'b0, cur} - {1'b0, step};

    always_comb begin
        next = cur;
        if (cur < goal) begin
            if (w_up >= {1'b0, goal}) begin
                next = goal;
            end else begin
                next = w_up[W-1:0];
            end
        end else if (cur > goal) begin
            if (w_dn[W] || (w_dn[W-1:0] <= goal)) begin
                next = goal;
            end else begin
                next = w_dn[W-1:0];
            end
        end
    end

endmodule : gain_slew
`default_nettype wire

// File: rtl/rf_output_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_output_sequencer
// Purpose  : Sequences the AM transmitter output around the watchdog:
//            arms the watchdog, ramps modulator gain up/down at a bounded
//            slew, and mutes + latches a fault when the watchdog fires.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            host_enable      - level request for RF output
//            host_heartbeat   - host keep-alive pulse
//            target_gain      - requested steady-state gain
//            fault_clear      - pulse acknowledging a latched fault
//            wd_force_reset   - watchdog timeout indication
//            wd_enable        - watchdog enable
//            wd_heartbeat     - watchdog heartbeat (registered host pulse)
//            rf_enable        - modulator output gate
//            rf_gain          - modulator gain
//            fault_latched    - sticky watchdog fault flag
//            state            - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module rf_output_sequencer
    import am_ctrl_pkg::*;
#(
    parameter int                GAIN_W     = c_gain_w,
    parameter logic [GAIN_W-1:0] RAMP_STEP  = GAIN_W'(c_ramp_step),
    parameter int                ARM_CYCLES = c_arm_cycles,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_enable,
    input  logic              host_heartbeat,
    input  logic [GAIN_W-1:0] target_gain,
    input  logic              fault_clear,
    input  logic              wd_force_reset,
    output logic              wd_enable,
    output logic              wd_heartbeat,
    output logic              rf_enable,
    output logic [GAIN_W-1:0] rf_gain,
    output logic              fault_latched,
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] c_arm_load = CNT_W'(ARM_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_arm_cnt;
    logic [GAIN_W-1:0] r_gain;
    logic              r_rf_enable;
    logic              r_wd_enable;
    logic              r_wd_heartbeat;
    logic              r_fault;

    logic [GAIN_W-1:0] w_goal;
    logic [GAIN_W-1:0] w_next_gain;
    logic              w_wd_armed;

    // Ramp-down always heads for zero; every other state follows the host.
    assign w_goal = (r_state == ST_RAMP_DOWN) ? '0 : target_gain;

    // Watchdog timeouts are meaningful only once it has been armed.
    assign w_wd_armed = (r_state != ST_IDLE);

    gain_slew #(
        .W (GAIN_W)
    ) u_gain_slew (
        .cur  (r_gain),
        .goal (w_goal),
        .step (RAMP_STEP),
        .next (w_next_gain)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_arm_cnt      <= '0;
            r_gain         <= '0;
            r_rf_enable    <= 1'b0;
            r_wd_enable    <= 1'b0;
            r_wd_heartbeat <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            // Heartbeat follows the host one cycle late, gated by the
            // watchdog enable that will be in effect; branches that change
            // wd_enable override this with the matching gate.
            r_wd_heartbeat <= host_heartbeat & r_wd_enable;

            if (w_wd_armed && wd_force_reset) begin
                r_state        <= ST_FAULT;
                r_gain         <= '0;
                r_rf_enable    <= 1'b0;
                r_wd_enable    <= 1'b0;
                r_wd_heartbeat <= 1'b0;
                r_fault        <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (host_enable && !r_fault) begin
                            r_state        <= ST_ARM;
                            r_wd_enable    <= 1'b1;
                            r_wd_heartbeat <= host_heartbeat;
                            r_arm_cnt      <= c_arm_load;
                        end
                    end
                    ST_ARM: begin
                        if (!host_enable) begin
                            r_state <= ST_RAMP_DOWN;
                        end else if (r_arm_cnt == '0) begin
                            r_state     <= ST_RAMP_UP;
                            r_rf_enable <= 1'b1;
                        end else begin
                            r_arm_cnt <= r_arm_cnt - CNT_W'(1);
                        end
                    end
                    ST_RAMP_UP: begin
                        if (!host_enable) begin
                            r_state <= ST_RAMP_DOWN;
                        end else begin
                            r_gain <= w_next_gain;
                            if (r_gain == target_gain) begin
                                r_state <= ST_ON;
                            end
                        end
                    end
                    ST_ON: begin
                        if (!host_enable) begin
                            r_state <= ST_RAMP_DOWN;
                        end else begin
                            r_gain <= w_next_gain;
                        end
                    end
                    ST_RAMP_DOWN: begin
                        // host_enable is deliberately ignored here; re-entry
                        // must pass through IDLE and a fresh ARM period.
                        if (r_gain == '0) begin
                            r_state        <= ST_IDLE;
                            r_rf_enable    <= 1'b0;
                            r_wd_enable    <= 1'b0;
                            r_wd_heartbeat <= 1'b0;
                        end else begin
                            r_gain <= w_next_gain;
                        end
                    end
                    ST_FAULT: begin
                        // Clearing requires the host to have dropped its
                        // request, so RF cannot restart on the same cycle.
                        if (fault_clear && !host_enable) begin
                            r_state <= ST_IDLE;
                            r_fault <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= c_safe_state;
                        r_gain         <= '0;
                        r_rf_enable    <= 1'b0;
                        r_wd_enable    <= 1'b0;
                        r_wd_heartbeat <= 1'b0;
                        r_fault        <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state         = r_state;
    assign rf_gain       = r_gain;
    assign rf_enable     = r_rf_enable;
    assign wd_enable     = r_wd_enable;
    assign wd_heartbeat  = r_wd_heartbeat;
    assign fault_latched = r_fault;

endmodule : rf_output_sequencer
`default_nettype wire

// File: tb/tb_rf_output_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_output_sequencer
// Purpose  : Self-checking bench for rf_output_sequencer with
//            ARM_CYCLES=4 and RAMP_STEP=16'h1000. A vector table covers
//            reset and bring-up; hand sequences cover saturation, shutdown,
//            fault handling, heartbeat gating and reset mid-ramp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_output_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_enable;
    logic        host_heartbeat;
    logic [15:0] target_gain;
    logic        fault_clear;
    logic        wd_force_reset;
    logic        wd_enable;
    logic        wd_heartbeat;
    logic        rf_enable;
    logic [15:0] rf_gain;
    logic        fault_latched;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rf_output_sequencer #(
        .GAIN_W     (16),
        .RAMP_STEP  (16'h1000),
        .ARM_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_enable    (host_enable),
        .host_heartbeat (host_heartbeat),
        .target_gain    (target_gain),
        .fault_clear    (fault_clear),
        .wd_force_reset (wd_force_reset),
        .wd_enable      (wd_enable),
        .wd_heartbeat   (wd_heartbeat),
        .rf_enable      (rf_enable),
        .rf_gain        (rf_gain),
        .fault_latched  (fault_latched),
        .state          (state)
    );

    typedef struct {
        logic        rst;
        logic        he;
        logic        hb;
        logic [15:0] tg;
        logic [2:0]  e_st;
        logic [15:0] e_gain;
        logic        e_rfen;
        logic        e_wden;
        logic        e_hb;
        logic        e_flt;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic r, input logic he, input logic hb,
                                input logic [15:0] tg, input logic [2:0] st,
                                input logic [15:0] g, input logic rfen,
                                input logic wden, input logic ehb,
                                input logic flt);
        vec_t v;
        v.rst = r;   v.he = he;     v.hb = hb;     v.tg = tg;
        v.e_st = st; v.e_gain = g;  v.e_rfen = rfen;
        v.e_wden = wden; v.e_hb = ehb; v.e_flt = flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st,
                              input logic [15:0] g, input logic rfen,
                              input logic wden, input logic hb,
                              input logic flt);
        chk({tag, ".state"},         32'(state),         32'(st));
        chk({tag, ".rf_gain"},       32'(rf_gain),       32'(g));
        chk({tag, ".rf_enable"},     32'(rf_enable),     32'(rfen));
        chk({tag, ".wd_enable"},     32'(wd_enable),     32'(wden));
        chk({tag, ".wd_heartbeat"},  32'(wd_heartbeat),  32'(hb));
        chk({tag, ".fault_latched"}, 32'(fault_latched), 32'(flt));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; host_enable = 1'b0; host_heartbeat = 1'b0;
        target_gain = 16'h0; fault_clear = 1'b0; wd_force_reset = 1'b0;

        // Reset, enable, four ARM cycles (heartbeat pulsed in ARM), ramp to
        // 0x3000, ON, then a downward target change that saturates in one step.
        vecs[0]  = mk(1, 0, 0, 16'h0000, 3'd0, 16'h0000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 16'h0000, 3'd0, 16'h0000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 16'h3000, 3'd1, 16'h0000, 0, 1, 0, 0);
        vecs[3]  = mk(0, 1, 1, 16'h3000, 3'd1, 16'h0000, 0, 1, 1, 0);
        vecs[4]  = mk(0, 1, 0, 16'h3000, 3'd1, 16'h0000, 0, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 16'h3000, 3'd1, 16'h0000, 0, 1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 16'h3000, 3'd2, 16'h0000, 1, 1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 16'h3000, 3'd2, 16'h1000, 1, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 16'h3000, 3'd2, 16'h2000, 1, 1, 0, 0);
        vecs[9]  = mk(0, 1, 0, 16'h3000, 3'd2, 16'h3000, 1, 1, 0, 0);
        vecs[10] = mk(0, 1, 0, 16'h3000, 3'd3, 16'h3000, 1, 1, 0, 0);
        vecs[11] = mk(0, 1, 0, 16'h2800, 3'd3, 16'h2800, 1, 1, 0, 0);
        vecs[12] = mk(0, 1, 0, 16'h2800, 3'd3, 16'h2800, 1, 1, 0, 0);

        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; host_enable = vecs[i].he;
            host_heartbeat = vecs[i].hb; target_gain = vecs[i].tg;
            cycle();
            expect_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_gain,
                       vecs[i].e_rfen, vecs[i].e_wden, vecs[i].e_hb,
                       vecs[i].e_flt);
        end

        // Upward slew to full scale: 0x2800 -> 0xF800 in 13 steps, then
        // the final step saturates at 0xFFFF without wrapping.
        target_gain = 16'hFFFF;
        for (int k = 1; k <= 13; k++) begin
            cycle();
            chk($sformatf("sat_up%0d.rf_gain", k), 32'(rf_gain),
                32'h2800 + 32'(k) * 32'h1000);
        end
        cycle();
        expect_all("sat_top", 3'd3, 16'hFFFF, 1, 1, 0, 0);
        cycle();
        chk("sat_hold.rf_gain", 32'(rf_gain), 32'hFFFF);

        // Downward slew back to 0x3000: 0xFFFF - k*0x1000, last step clamps.
        target_gain = 16'h3000;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk($sformatf("sat_dn%0d.rf_gain", k), 32'(rf_gain),
                32'hFFFF - 32'(k) * 32'h1000);
        end
        cycle();
        expect_all("sat_dn_end", 3'd3, 16'h3000, 1, 1, 0, 0);

        // Orderly shutdown with a host_enable pulse mid-ramp.
        host_enable = 1'b0;
        cycle(); expect_all("off0", 3'd4, 16'h3000, 1, 1, 0, 0);
        host_enable = 1'b1;
        cycle(); expect_all("off1", 3'd4, 16'h2000, 1, 1, 0, 0);
        host_enable = 1'b0;
        cycle(); expect_all("off2", 3'd4, 16'h1000, 1, 1, 0, 0);
        cycle(); expect_all("off3", 3'd4, 16'h0000, 1, 1, 0, 0);
        cycle(); expect_all("off_idle", 3'd0, 16'h0000, 0, 0, 0, 0);

        // Heartbeat in IDLE is gated; watchdog timeout in IDLE is ignored.
        host_heartbeat = 1'b1;
        cycle(); expect_all("idle_hb", 3'd0, 16'h0000, 0, 0, 0, 0);
        host_heartbeat = 1'b0; wd_force_reset = 1'b1;
        cycle(); expect_all("idle_wdr", 3'd0, 16'h0000, 0, 0, 0, 0);
        wd_force_reset = 1'b0;

        // Bring up again, then watchdog fault while ON.
        host_enable = 1'b1; target_gain = 16'h3000;
        cycle(); expect_all("re_arm", 3'd1, 16'h0000, 0, 1, 0, 0);
        repeat (3) cycle();
        cycle(); expect_all("re_ramp", 3'd2, 16'h0000, 1, 1, 0, 0);
        repeat (3) cycle();
        cycle(); expect_all("re_on", 3'd3, 16'h3000, 1, 1, 0, 0);
        wd_force_reset = 1'b1;
        cycle(); expect_all("fault", 3'd5, 16'h0000, 0, 0, 0, 1);
        wd_force_reset = 1'b0;
        cycle(); expect_all("fault_hold", 3'd5, 16'h0000, 0, 0, 0, 1);
        fault_clear = 1'b1;
        cycle(); expect_all("clr_he1", 3'd5, 16'h0000, 0, 0, 0, 1);
        host_enable = 1'b0;
        cycle(); expect_all("clr_he0", 3'd0, 16'h0000, 0, 0, 0, 0);
        fault_clear = 1'b0;

        // Re-arm after clear, heartbeat on the arming edge, reset mid-ramp.
        host_enable = 1'b1; host_heartbeat = 1'b1;
        cycle(); expect_all("arm2", 3'd1, 16'h0000, 0, 1, 1, 0);
        host_heartbeat = 1'b0;
        cycle(); expect_all("arm2_hb0", 3'd1, 16'h0000, 0, 1, 0, 0);
        repeat (2) cycle();
        cycle(); expect_all("ramp2", 3'd2, 16'h0000, 1, 1, 0, 0);
        cycle(); expect_all("ramp2_g", 3'd2, 16'h1000, 1, 1, 0, 0);
        rst = 1'b1; host_heartbeat = 1'b1;
        cycle(); expect_all("rst_mid", 3'd0, 16'h0000, 0, 0, 0, 0);
        rst = 1'b0; host_enable = 1'b0; host_heartbeat = 1'b0;
        cycle(); expect_all("post_rst", 3'd0, 16'h0000, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rf_output_sequencer
`default_nettype wire
